// File: rtl/uart_cmd_ctrl.sv
// UART command controller: parses A5/CMD/DHI/DLO/CS packets into a 4-entry register file and answers ACK/NAK.
// Define UART_CMD_READBACK_EN to enable read commands; without it, reads are answered with NAK.
module uart_cmd_ctrl #(
  parameter int TIMEOUT_CYCLES = 8680
) (
  input  logic        ipClk,
  input  logic        ipReset,
  input  logic [7:0]  ipRxData,
  input  logic        ipRxValid,
  output logic [7:0]  opTxData,
  output logic        opTxSend,
  input  logic        ipTxBusy,
  output logic [15:0] opFreq,
  output logic [15:0] opAmp,
  output logic [1:0]  opWave,
  output logic        opOutEn,
  output logic        opBusy
);

  localparam logic [3:0] P_HDR    = 4'd0;
  localparam logic [3:0] P_CMD    = 4'd1;
  localparam logic [3:0] P_DHI    = 4'd2;
  localparam logic [3:0] P_DLO    = 4'd3;
  localparam logic [3:0] P_CS     = 4'd4;
  localparam logic [3:0] EXEC     = 4'd5;
  localparam logic [3:0] TX_LOAD  = 4'd6;
  localparam logic [3:0] TX_WBUSY = 4'd7;
  localparam logic [3:0] TX_WDONE = 4'd8;

  localparam logic [7:0] HDR_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  localparam int          IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  logic [3:0]        state;
  logic              rxPrev;
  logic              rxByte;
  logic [7:0]        cmdReg;
  logic [7:0]        dhiReg;
  logic [7:0]        dloReg;
  logic [7:0]        csReg;
  logic [IDLE_W-1:0] idleCnt;
  logic              inPacket;
  logic              timedOut;
  logic              cmdOk;
  logic              cmdAck;
  logic [7:0]        txBuf [4];
  logic [1:0]        txHead;
  logic [2:0]        txCnt;

  assign rxByte   = ipRxValid && !rxPrev;
  assign inPacket = (state == P_CMD) || (state == P_DHI) || (state == P_DLO) || (state == P_CS);
  assign timedOut = inPacket && !rxByte && (idleCnt == IDLE_LAST);
  assign cmdOk    = (csReg == (cmdReg ^ dhiReg ^ dloReg)) && (cmdReg[6:0] <= 7'd3);
  assign opBusy   = (state != P_HDR);

`ifdef UART_CMD_READBACK_EN
  logic [15:0] readVal;

  assign cmdAck = cmdOk;

  // NOTE: give every always_comb output a default first, or a missed branch infers a latch.
  always_comb begin
    readVal = '0;
    case (cmdReg[1:0])
      2'd0: readVal = opFreq;
      2'd1: readVal = opAmp;
      2'd2: readVal = {14'd0, opWave};
      2'd3: readVal = {15'd0, opOutEn};
    endcase
  end
`else
  assign cmdAck = cmdOk && !cmdReg[7];
`endif

  // Idle counter only runs between bytes of a packet and restarts on every accepted byte.
  always_ff @(posedge ipClk) begin
    if (ipReset || !inPacket || rxByte || timedOut) idleCnt <= '0;
    else                                            idleCnt <= idleCnt + 1'b1;
  end

  // NOTE: the response buffer is data-only and always written before it is read, so it carries no reset.
  always_ff @(posedge ipClk) begin
    if (state == EXEC) begin
      txBuf[0] <= cmdAck ? ACK_BYTE : NAK_BYTE;
      txBuf[1] <= cmdReg;
`ifdef UART_CMD_READBACK_EN
      txBuf[2] <= readVal[15:8];
      txBuf[3] <= readVal[7:0];
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      state    <= P_HDR;
      rxPrev   <= 1'b1;
      cmdReg   <= '0;
      dhiReg   <= '0;
      dloReg   <= '0;
      csReg    <= '0;
      txHead   <= '0;
      txCnt    <= '0;
      opTxData <= '0;
      opTxSend <= 1'b0;
      opFreq   <= '0;
      opAmp    <= '0;
      opWave   <= '0;
      opOutEn  <= 1'b0;
    end else begin
      rxPrev <= ipRxValid;
      case (state)
        P_HDR: if (rxByte && ipRxData == HDR_BYTE) state <= P_CMD;
        P_CMD: begin
          if (rxByte)        begin cmdReg <= ipRxData; state <= P_DHI; end
          else if (timedOut) state <= P_HDR;
        end
        P_DHI: begin
          if (rxByte)        begin dhiReg <= ipRxData; state <= P_DLO; end
          else if (timedOut) state <= P_HDR;
        end
        P_DLO: begin
          if (rxByte)        begin dloReg <= ipRxData; state <= P_CS; end
          else if (timedOut) state <= P_HDR;
        end
        P_CS: begin
          if (rxByte)        begin csReg <= ipRxData; state <= EXEC; end
          else if (timedOut) state <= P_HDR;
        end
        EXEC: begin
          txHead <= '0;
          txCnt  <= 3'd2;
          if (cmdAck && !cmdReg[7]) begin
            case (cmdReg[1:0])
              2'd0: opFreq  <= {dhiReg, dloReg};
              2'd1: opAmp   <= {dhiReg, dloReg};
              2'd2: opWave  <= dloReg[1:0];
              2'd3: opOutEn <= dloReg[0];
            endcase
          end
`ifdef UART_CMD_READBACK_EN
          if (cmdAck && cmdReg[7]) txCnt <= 3'd4;
`endif
          state <= TX_LOAD;
        end
        TX_LOAD: begin
          if (txCnt == 3'd0) begin
            state <= P_HDR;
          end else begin
            opTxData <= txBuf[txHead];
            opTxSend <= 1'b1;
            state    <= TX_WBUSY;
          end
        end
        TX_WBUSY: begin
          if (ipTxBusy) begin
            opTxSend <= 1'b0;
            state    <= TX_WDONE;
          end
        end
        TX_WDONE: begin
          if (!ipTxBusy) begin
            txHead <= txHead + 1'b1;
            txCnt  <= txCnt - 1'b1;
            state  <= TX_LOAD;
          end
        end
        default: state <= P_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: vector table, timing corner cases and random packets vs a reference model.
module tb_uart_cmd_ctrl;

  localparam int TIMEOUT = 8680;

  logic        ipClk = 1'b0;
  logic        ipReset;
  logic [7:0]  ipRxData;
  logic        ipRxValid;
  logic [7:0]  opTxData;
  logic        opTxSend;
  logic        ipTxBusy;
  logic [15:0] opFreq;
  logic [15:0] opAmp;
  logic [1:0]  opWave;
  logic        opOutEn;
  logic        opBusy;

  always #5 ipClk = ~ipClk;

  uart_cmd_ctrl #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .ipClk    (ipClk),
    .ipReset  (ipReset),
    .ipRxData (ipRxData),
    .ipRxValid(ipRxValid),
    .opTxData (opTxData),
    .opTxSend (opTxSend),
    .ipTxBusy (ipTxBusy),
    .opFreq   (opFreq),
    .opAmp    (opAmp),
    .opWave   (opWave),
    .opOutEn  (opOutEn),
    .opBusy   (opBusy)
  );

  typedef struct {
    logic [39:0] pkt;
    int          len;
    logic [31:0] resp;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [15:0] mFreq, mAmp;
  logic [1:0]  mWave;
  logic        mOutEn;
  logic [7:0]  txQ[$];
  logic [7:0]  expQ[$];
  logic [7:0]  mQ[$];
  bit          txStall = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Behavioural transmitter: accepts a send request, stays busy a random time, checks data stability.
  initial begin
    logic [7:0] cap;
    ipTxBusy = 1'b0;
    forever begin
      @(negedge ipClk);
      if (opTxSend && !ipTxBusy && !txStall && !ipReset) begin
        cap = opTxData;
        txQ.push_back(cap);
        ipTxBusy = 1'b1;
        repeat ($urandom_range(1, 4)) begin
          @(negedge ipClk);
          if (!ipReset) check("tx_data_stable", {24'd0, opTxData}, {24'd0, cap});
        end
        ipTxBusy = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic sendByte(input logic [7:0] b, input int hold, input int gap);
    @(negedge ipClk);
    ipRxData  = b;
    ipRxValid = 1'b1;
    repeat (hold) @(negedge ipClk);
    ipRxValid = 1'b0;
    repeat (gap) @(negedge ipClk);
  endtask

  task automatic sendPkt(input logic [39:0] p, input int hold, input int gap);
    for (int i = 0; i < 5; i++) sendByte(p[39-8*i -: 8], hold, gap);
  endtask

  // Reference model: applies the packet rules directly to the model register file.
  task automatic modelPkt(input logic [39:0] p);
    logic [7:0]  cmd, dhi, dlo, cs;
    logic [15:0] v;
    cmd = p[31:24]; dhi = p[23:16]; dlo = p[15:8]; cs = p[7:0];
    mQ.delete();
    if (cs != (cmd ^ dhi ^ dlo) || cmd[6:0] > 7'd3) begin
      mQ.push_back(8'h15); mQ.push_back(cmd);
    end else if (!cmd[7]) begin
      mQ.push_back(8'h06); mQ.push_back(cmd);
      if (cmd[1:0] == 2'd0)      mFreq  = {dhi, dlo};
      else if (cmd[1:0] == 2'd1) mAmp   = {dhi, dlo};
      else if (cmd[1:0] == 2'd2) mWave  = dlo[1:0];
      else                       mOutEn = dlo[0];
    end else begin
`ifdef UART_CMD_READBACK_EN
      if (cmd[1:0] == 2'd0)      v = mFreq;
      else if (cmd[1:0] == 2'd1) v = mAmp;
      else if (cmd[1:0] == 2'd2) v = 16'(mWave);
      else                       v = 16'(mOutEn);
      mQ.push_back(8'h06); mQ.push_back(cmd); mQ.push_back(v[15:8]); mQ.push_back(v[7:0]);
`else
      v = 16'd0;
      mQ.push_back(8'h15); mQ.push_back(cmd);
`endif
    end
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while ((opBusy || ipTxBusy) && n < 500) begin
      @(negedge ipClk);
      n++;
    end
    check({name, "_idle"}, {31'd0, opBusy}, 32'd0);
  endtask

  task automatic compareResp(input string name);
    check({name, "_resp_len"}, txQ.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < txQ.size(); i++)
      check($sformatf("%s_resp_byte%0d", name, i), {24'd0, txQ[i]}, {24'd0, expQ[i]});
    txQ.delete();
    expQ.delete();
  endtask

  task automatic checkRegs(input string name);
    check({name, "_freq"},  {16'd0, opFreq},  {16'd0, mFreq});
    check({name, "_amp"},   {16'd0, opAmp},   {16'd0, mAmp});
    check({name, "_wave"},  {30'd0, opWave},  {30'd0, mWave});
    check({name, "_outen"}, {31'd0, opOutEn}, {31'd0, mOutEn});
  endtask

  task automatic runPkt(input string name, input logic [39:0] p, input int hold, input int gap);
    sendPkt(p, hold, gap);
    modelPkt(p);
    waitIdle(name);
    expQ = mQ;
    compareResp(name);
    checkRegs(name);
  endtask

  vec_t vecs [9];

  initial begin
    logic [39:0] p;
    logic [7:0]  cmd, dhi, dlo, cs, g;

    vecs[0] = '{40'hA5_00_12_34_26, 2, 32'h06_00_00_00};
    vecs[1] = '{40'hA5_01_00_80_81, 2, 32'h06_01_00_00};
    vecs[2] = '{40'hA5_02_00_03_00, 2, 32'h15_02_00_00};
    vecs[3] = '{40'hA5_05_00_00_05, 2, 32'h15_05_00_00};
    vecs[4] = '{40'hA5_02_FF_03_FE, 2, 32'h06_02_00_00};
    vecs[5] = '{40'hA5_03_55_01_57, 2, 32'h06_03_00_00};
`ifdef UART_CMD_READBACK_EN
    vecs[6] = '{40'hA5_81_00_00_81, 4, 32'h06_81_00_80};
    vecs[7] = '{40'hA5_82_00_00_82, 4, 32'h06_82_00_03};
    vecs[8] = '{40'hA5_80_00_00_80, 4, 32'h06_80_12_34};
`else
    vecs[6] = '{40'hA5_81_00_00_81, 2, 32'h15_81_00_00};
    vecs[7] = '{40'hA5_82_00_00_82, 2, 32'h15_82_00_00};
    vecs[8] = '{40'hA5_80_00_00_80, 2, 32'h15_80_00_00};
`endif

    ipReset = 1'b1; ipRxValid = 1'b0; ipRxData = 8'h00;
    mFreq = '0; mAmp = '0; mWave = '0; mOutEn = 1'b0;
    repeat (3) @(negedge ipClk);
    check("reset_txsend", {31'd0, opTxSend}, 32'd0);
    check("reset_txdata", {24'd0, opTxData}, 32'd0);
    check("reset_busy",   {31'd0, opBusy},   32'd0);
    checkRegs("reset");
    ipReset = 1'b0;
    repeat (2) @(negedge ipClk);

    // Register write lands on the EXEC edge and is visible the cycle after EXEC.
    sendByte(8'hA5, 1, 1); sendByte(8'h00, 1, 1); sendByte(8'hAB, 1, 1); sendByte(8'hCD, 1, 1);
    @(negedge ipClk);
    ipRxData = 8'h66; ipRxValid = 1'b1;
    @(negedge ipClk);
    ipRxValid = 1'b0;
    check("exec_freq_old", {16'd0, opFreq}, 32'h0);
    check("exec_busy",     {31'd0, opBusy}, 32'd1);
    @(negedge ipClk);
    check("exec_freq_new", {16'd0, opFreq}, 32'hABCD);
    modelPkt(40'hA5_00_AB_CD_66);
    waitIdle("exec");
    expQ = mQ;
    compareResp("exec");

    for (int i = 0; i < 9; i++) begin
      sendPkt(vecs[i].pkt, $urandom_range(1, 3), $urandom_range(1, 3));
      modelPkt(vecs[i].pkt);
      waitIdle($sformatf("vec%0d", i));
      for (int k = 0; k < vecs[i].len; k++) expQ.push_back(vecs[i].resp[31-8*k -: 8]);
      compareResp($sformatf("vec%0d", i));
      checkRegs($sformatf("vec%0d", i));
    end

    // Inter-byte timeout: silent abandon, trailing bytes are not headers.
    sendByte(8'hA5, 1, 0); sendByte(8'h03, 1, 0);
    repeat (TIMEOUT - 20) @(negedge ipClk);
    check("timeout_before", {31'd0, opBusy}, 32'd1);
    repeat (40) @(negedge ipClk);
    check("timeout_after", {31'd0, opBusy}, 32'd0);
    sendByte(8'h00, 2, 2); sendByte(8'h01, 2, 2); sendByte(8'h02, 2, 2);
    repeat (10) @(negedge ipClk);
    check("timeout_trail_busy", {31'd0, opBusy}, 32'd0);
    compareResp("timeout");
    checkRegs("timeout");

    // Bytes just inside the timeout window restart the idle count.
    sendByte(8'hA5, 1, 0); sendByte(8'h00, 1, 0);
    repeat (TIMEOUT - 30) @(negedge ipClk);
    sendByte(8'h12, 1, 0);
    repeat (TIMEOUT - 30) @(negedge ipClk);
    sendByte(8'h34, 1, 0);
    repeat (TIMEOUT - 30) @(negedge ipClk);
    sendByte(8'h26, 1, 0);
    modelPkt(40'hA5_00_12_34_26);
    waitIdle("near_timeout");
    expQ = mQ;
    compareResp("near_timeout");
    checkRegs("near_timeout");

    // Long valid pulses parse once each; a packet injected mid-response is dropped.
    txStall = 1'b1;
    sendPkt(40'hA5_01_12_34_27, 434, 434);
    modelPkt(40'hA5_01_12_34_27);
    check("long_send_held", {31'd0, opTxSend}, 32'd1);
    sendPkt(40'hA5_00_00_00_00, 2, 2);
    txStall = 1'b0;
    waitIdle("long");
    expQ = mQ;
    compareResp("long");
    checkRegs("long");

    // Reset while waiting for the transmitter, with valid already high at release.
    txStall = 1'b1;
    sendPkt(40'hA5_00_77_88_FF, 2, 2);
    check("wbusy_send",  {31'd0, opTxSend}, 32'd1);
    check("wbusy_freq",  {16'd0, opFreq},   32'h7788);
    @(negedge ipClk);
    ipReset = 1'b1; ipRxValid = 1'b1; ipRxData = 8'hA5;
    @(negedge ipClk);
    mFreq = '0; mAmp = '0; mWave = '0; mOutEn = 1'b0;
    check("rst_txsend", {31'd0, opTxSend}, 32'd0);
    check("rst_txdata", {24'd0, opTxData}, 32'd0);
    check("rst_busy",   {31'd0, opBusy},   32'd0);
    checkRegs("rst");
    ipReset = 1'b0;
    txStall = 1'b0;
    txQ.delete();
    repeat (5) @(negedge ipClk);
    check("rst_valid_high_ignored", {31'd0, opBusy}, 32'd0);
    ipRxValid = 1'b0;
    repeat (2) @(negedge ipClk);

    for (int n = 0; n < 40; n++) begin
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h00;
        sendByte(g, $urandom_range(1, 3), $urandom_range(1, 3));
      end
      cmd = {1'($urandom), 7'($urandom_range(0, 5))};
      dhi = 8'($urandom);
      dlo = 8'($urandom);
      cs  = cmd ^ dhi ^ dlo;
      if ($urandom_range(0, 3) == 0) cs = cs ^ 8'(1 << $urandom_range(0, 7));
      p = {8'hA5, cmd, dhi, dlo, cs};
      runPkt($sformatf("rand%0d", n), p, $urandom_range(1, 3), $urandom_range(1, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
